// File: rtl/test_pkg.sv
// Shared types and constants for the adder result checker.
package test_pkg;

  localparam int DATA_W = 8;

  // Nibble-swapped view of the adder sum as it is returned on struct_in.
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } nibPair_t;

  localparam logic [1:0] STAT_ZERO  = 2'b00;
  localparam logic [1:0] STAT_MAX   = 2'b01;
  localparam logic [1:0] STAT_OTHER = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [1:0] classifySum(input logic [DATA_W-1:0] s);
    logic [1:0] cls;
    if (s == '0) begin
      cls = STAT_ZERO;
    end else if (s == '1) begin
      cls = STAT_MAX;
    end else begin
      cls = STAT_OTHER;
    end
    return cls;
  endfunction

endpackage

// File: rtl/test_expect.sv
// Derives the expected status/struct for a predicted sum and validates the constant table.
module test_expect
  import test_pkg::*;
(
  input  logic [DATA_W-1:0] expSum_i,
  input  logic [3:0]        arrayIn_i [4][4],
  output logic [1:0]        expStatus_o,
  output logic [DATA_W-1:0] expStruct_o,
  output logic              arrayMatch_o
);

  nibPair_t swapped;

  always_comb begin
    expStatus_o = classifySum(expSum_i);
  end

  always_comb begin
    swapped.x   = expSum_i[3:0];
    swapped.y   = expSum_i[7:4];
    expStruct_o = swapped;
  end

  // Table entry [i][j] must hold (i+j) mod 16.
  always_comb begin
    arrayMatch_o = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (arrayIn_i[i][j] != 4'((i + j) % 16)) begin
          arrayMatch_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/test_checker.sv
// Run controller for the adder checker: accepts operand pairs, predicts the registered
// sum one cycle later and tallies mismatching cycles.
module test_checker
  import test_pkg::*;
#(
  parameter int NUM_VECTORS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] sum,
  input  logic [1:0]        status,
  input  logic [DATA_W-1:0] struct_in,
  input  logic [3:0]        array_in [4][4],
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [7:0]        first_err_idx,
  output logic [7:0]        vec_count
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);
  localparam logic [7:0] NO_ERR   = 8'hFF;

  state_t            state_q, state_d;
  logic [7:0]        vecCount_q, vecCount_d;
  logic [7:0]        errCount_q, errCount_d;
  logic [7:0]        firstErrIdx_q, firstErrIdx_d;
  logic [DATA_W-1:0] expSum_q, expSum_d;
  logic [7:0]        expIdx_q, expIdx_d;
  logic              expValid_q, expValid_d;

  logic [1:0]        expStatus;
  logic [DATA_W-1:0] expStruct;
  logic              arrayMatch;
  logic              checkActive;
  logic              dataMismatch;
  logic              cycleErr;

  test_expect u_expect (
    .expSum_i    (expSum_q),
    .arrayIn_i   (array_in),
    .expStatus_o (expStatus),
    .expStruct_o (expStruct),
    .arrayMatch_o(arrayMatch)
  );

  // The table is checked on every busy cycle; data only when a prediction is pending.
  always_comb begin
    checkActive  = (state_q == RUN) || (state_q == DRAIN);
    dataMismatch = expValid_q && ((sum != expSum_q) ||
                                  (status != expStatus) ||
                                  (struct_in != expStruct));
    cycleErr     = checkActive && (dataMismatch || !arrayMatch);
  end

  always_comb begin
    state_d       = state_q;
    vecCount_d    = vecCount_q;
    errCount_d    = errCount_q;
    firstErrIdx_d = firstErrIdx_q;
    expSum_d      = expSum_q;
    expIdx_d      = expIdx_q;
    expValid_d    = 1'b0;

    if (cycleErr) begin
      if (errCount_q != 8'hFF) begin
        errCount_d = errCount_q + 8'd1;
      end
      if (errCount_q == 8'd0) begin
        firstErrIdx_d = expValid_q ? expIdx_q : vecCount_q;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = RUN;
          vecCount_d    = 8'd0;
          errCount_d    = 8'd0;
          firstErrIdx_d = NO_ERR;
        end
      end
      RUN: begin
        if (in_valid) begin
          expSum_d   = a + b;
          expValid_d = 1'b1;
          expIdx_d   = vecCount_q;
          vecCount_d = vecCount_q + 8'd1;
          if (vecCount_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      vecCount_q    <= 8'd0;
      errCount_q    <= 8'd0;
      firstErrIdx_q <= NO_ERR;
      expSum_q      <= '0;
      expIdx_q      <= 8'd0;
      expValid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vecCount_q    <= vecCount_d;
      errCount_q    <= errCount_d;
      firstErrIdx_q <= firstErrIdx_d;
      expSum_q      <= expSum_d;
      expIdx_q      <= expIdx_d;
      expValid_q    <= expValid_d;
    end
  end

  always_comb begin
    busy          = checkActive;
    done          = (state_q == DONE);
    pass          = (state_q == DONE) && (errCount_q == 8'd0);
    err_count     = errCount_q;
    first_err_idx = firstErrIdx_q;
    vec_count     = vecCount_q;
  end

endmodule

// File: tb/tb_test_checker.sv
// Directed/randomized bench for test_checker with a registered adder model and a run-level result model.
module tb_test_checker;

  localparam int NV = 16;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       start     = 1'b0;
  logic       in_valid  = 1'b0;
  logic [7:0] a         = 8'd0;
  logic [7:0] b         = 8'd0;
  logic [7:0] sum       = 8'd0;
  logic [1:0] status;
  logic [7:0] struct_in;
  logic [3:0] array_in [4][4];
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [7:0] first_err_idx;
  logic [7:0] vec_count;

  logic       corrupt  = 1'b0;
  logic       breakArr = 1'b0;

  int         checkCount = 0;
  int         passCount  = 0;
  logic [7:0] opA [NV];
  logic [7:0] opB [NV];
  int         runCycles;
  int         expErr;
  logic [7:0] expFirst;

  test_checker #(.NUM_VECTORS(NV)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .a            (a),
    .b            (b),
    .sum          (sum),
    .status       (status),
    .struct_in    (struct_in),
    .array_in     (array_in),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .first_err_idx(first_err_idx),
    .vec_count    (vec_count)
  );

  always #5 clk = ~clk;

  // Adder under check: registered sum, optionally off by one on a chosen vector.
  always @(posedge clk) begin
    if (in_valid) sum <= a + b + (corrupt ? 8'd1 : 8'd0);
  end

  always_comb begin
    if (sum == 8'h00)      status = 2'b00;
    else if (sum == 8'hFF) status = 2'b01;
    else                   status = 2'b10;
    struct_in = {sum[3:0], sum[7:4]};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        array_in[i][j] = 4'((i + j) % 16);
    if (breakArr) array_in[3][3] = 4'd0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [7:0] av,
                               input logic [7:0] bv, input logic c);
    start    = s;
    in_valid = v;
    a        = av;
    b        = bv;
    corrupt  = c;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"},          {7'd0, busy},  8'd0);
    checkOutput({tag, " done"},          {7'd0, done},  8'd0);
    checkOutput({tag, " pass"},          {7'd0, pass},  8'd0);
    checkOutput({tag, " err_count"},     err_count,     8'd0);
    checkOutput({tag, " vec_count"},     vec_count,     8'd0);
    checkOutput({tag, " first_err_idx"}, first_err_idx, 8'hFF);
  endtask

  // One full run; expected totals come from counting busy cycles and injected faults.
  task automatic runVectors(input string tag, input int gapMin, input int gapMax,
                            input int corruptIdx, input logic brk, input int pokeIdx);
    int gaps;
    breakArr  = brk;
    runCycles = 0;
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int v = 0; v < NV; v++) begin
      gaps = int'($urandom_range(gapMax, gapMin));
      repeat (gaps) begin
        applyStimulus(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
        runCycles++;
      end
      applyStimulus(v == pokeIdx, 1'b1, opA[v], opB[v], v == corruptIdx);
      runCycles++;
      checkOutput({tag, " vec_count"}, vec_count, 8'(v + 1));
      checkOutput({tag, " busy"}, {7'd0, busy}, 8'd1);
    end
    checkOutput({tag, " drain done"}, {7'd0, done}, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

    if (brk) begin
      expErr   = (runCycles + 1 > 255) ? 255 : runCycles + 1;
      expFirst = 8'd0;
    end else if (corruptIdx >= 0 && corruptIdx < NV) begin
      expErr   = 1;
      expFirst = 8'(corruptIdx);
    end else begin
      expErr   = 0;
      expFirst = 8'hFF;
    end
    checkOutput({tag, " done"},          {7'd0, done}, 8'd1);
    checkOutput({tag, " busy"},          {7'd0, busy}, 8'd0);
    checkOutput({tag, " pass"},          {7'd0, pass}, (expErr == 0) ? 8'd1 : 8'd0);
    checkOutput({tag, " err_count"},     err_count,    8'(expErr));
    checkOutput({tag, " first_err_idx"}, first_err_idx, expFirst);
    checkOutput({tag, " final vec"},     vec_count,    8'(NV));
    breakArr = 1'b0;
  endtask

  task automatic randomOps();
    for (int i = 0; i < NV; i++) begin
      opA[i] = 8'($urandom);
      opB[i] = 8'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    checkResetState("reset");
    rst = 1'b0;

    repeat (3) applyStimulus(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
    checkOutput("idle valid vec_count", vec_count, 8'd0);
    checkOutput("idle valid busy", {7'd0, busy}, 8'd0);
    checkOutput("idle valid done", {7'd0, done}, 8'd0);

    for (int i = 0; i < NV; i++) begin
      opA[i] = 8'(i);
      opB[i] = 8'(2 * i);
    end
    runVectors("ramp", 0, 0, -1, 1'b0, 3);

    randomOps();
    opA[0] = 8'h80; opB[0] = 8'h80;
    opA[1] = 8'hFF; opB[1] = 8'h00;
    runVectors("edge sums", 0, 0, -1, 1'b0, -1);

    randomOps();
    runVectors("corrupt5", 0, 2, 5, 1'b0, -1);

    randomOps();
    runVectors("array b2b", 0, 0, -1, 1'b1, -1);

    randomOps();
    runVectors("array sat", 16, 20, -1, 1'b1, -1);

    randomOps();
    breakArr = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int v = 0; v < 7; v++) applyStimulus(1'b0, 1'b1, opA[v], opB[v], v == 2);
    checkOutput("abort vec_count", vec_count, 8'd7);
    breakArr = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'd1, 8'd1, 1'b0);
    checkResetState("abort reset");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    checkOutput("post reset busy", {7'd0, busy}, 8'd0);

    randomOps();
    runVectors("rerun", 0, 1, -1, 1'b0, -1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
